// File: rtl/fp_mul_seq_if.sv
// Handshake bus of the sequential floating-point multiplier: operand
// request channel (in_*, a, b) and result channel (out_*, c, flags).
interface fp_mul_seq_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] c;
    logic [3:0]   flags;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, c, flags
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, c, flags
    );
endinterface

// File: rtl/fp_mul_seq.sv
// Multi-cycle IEEE-754 multiplier: shift-add significand product, round to
// nearest even, flush-to-zero subnormals, flags {invalid, overflow, underflow, inexact}.
module fp_mul_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input logic         sysclk,
    input logic         rst,
    fp_mul_seq_if.slave bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int S  = MAN_W + 1;
    localparam int P  = 2 * S;
    localparam int XW = EXP_W + 2;
    localparam int CW = $clog2(S);
    localparam logic signed [XW-1:0] BIAS_X = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [XW-1:0] EMAX_X = XW'((1 << EXP_W) - 1);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, RND, DONE} state_t;
    state_t state, state_nx;

    logic                 sign;
    logic [S-1:0]         ma;
    logic [P-1:0]         prod;
    logic signed [XW-1:0] exp_r;
    logic [CW-1:0]        cnt;
    logic                 spec;
    logic [W-1:0]         spec_c;
    logic [3:0]           spec_f;
    logic [W-1:0]         c_r;
    logic [3:0]           flags_r;

    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
    logic             is_spec;
    logic [W-1:0]     sc;
    logic [3:0]       sf;
    logic             s_sign;

    assign ea = bus.a[W-2:MAN_W];
    assign fa = bus.a[MAN_W-1:0];
    assign eb = bus.b[W-2:MAN_W];
    assign fb = bus.b[MAN_W-1:0];

    // A zero exponent covers both zero and subnormal, so subnormals flush here.
    always_comb begin
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_inf  = (ea == '1) && (fa == '0);
        b_inf  = (eb == '1) && (fb == '0);
        a_nan  = (ea == '1) && (fa != '0);
        b_nan  = (eb == '1) && (fb != '0);
        a_snan = a_nan && !fa[MAN_W-1];
        b_snan = b_nan && !fb[MAN_W-1];
        s_sign = bus.a[W-1] ^ bus.b[W-1];
        is_spec = 1'b1;
        sc      = QNAN;
        sf      = '0;
        if (a_nan || b_nan)
            sf[3] = a_snan | b_snan;
        else if ((a_inf && b_zero) || (a_zero && b_inf))
            sf[3] = 1'b1;
        else if (a_inf || b_inf)
            sc = {s_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (a_zero || b_zero)
            sc = {s_sign, {(W-1){1'b0}}};
        else
            is_spec = 1'b0;
    end

    logic [S:0]           sum;
    logic                 norm, guard, sticky, rup;
    logic [S-1:0]         mant;
    logic [S:0]           mr;
    logic signed [XW-1:0] exp_n, exp_f;
    logic [MAN_W-1:0]     frac;
    logic [W-1:0]         rc;
    logic [3:0]           rf;

    assign sum = {1'b0, prod[P-1:S]} + (prod[0] ? {1'b0, ma} : '0);

    always_comb begin
        norm   = prod[P-1];
        mant   = norm ? prod[P-1:S] : prod[P-2:S-1];
        guard  = norm ? prod[S-1] : prod[S-2];
        sticky = norm ? (|prod[S-2:0]) : (|prod[S-3:0]);
        exp_n  = exp_r + $signed({{(XW-1){1'b0}}, norm});
        rup    = guard & (sticky | mant[0]);
        mr     = {1'b0, mant} + {{S{1'b0}}, rup};
        exp_f  = exp_n + $signed({{(XW-1){1'b0}}, mr[S]});
        frac   = mr[S] ? mr[MAN_W:1] : mr[MAN_W-1:0];
        if (spec) begin
            rc = spec_c;
            rf = spec_f;
        end else if (exp_f[XW-1] || exp_f == '0) begin
            rc = {sign, {(W-1){1'b0}}};
            rf = 4'b0011;
        end else if (exp_f >= EMAX_X) begin
            rc = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            rf = 4'b0101;
        end else begin
            rc = {sign, exp_f[EXP_W-1:0], frac};
            rf = {3'b000, guard | sticky};
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.in_valid)             state_nx = MUL;
            MUL:  if (cnt == CW'(S - 1))        state_nx = RND;
            RND:                                state_nx = DONE;
            DONE: if (bus.out_ready)            state_nx = IDLE;
            default:                            state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE) && !rst;
        bus.out_valid = (state == DONE);
        bus.c         = c_r;
        bus.flags     = flags_r;
    end

    // LSB-first multiplier: the multiplier sits in the low half of prod and
    // shifts out as the partial sum shifts in from the top.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            sign    <= 1'b0;
            ma      <= '0;
            prod    <= '0;
            exp_r   <= '0;
            cnt     <= '0;
            spec    <= 1'b0;
            spec_c  <= '0;
            spec_f  <= '0;
            c_r     <= '0;
            flags_r <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    sign   <= s_sign;
                    ma     <= {|ea, fa};
                    prod   <= {{S{1'b0}}, |eb, fb};
                    exp_r  <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_X;
                    cnt    <= '0;
                    spec   <= is_spec;
                    spec_c <= sc;
                    spec_f <= sf;
                end
                MUL: begin
                    prod <= {sum, prod[S-1:1]};
                    cnt  <= cnt + CW'(1);
                end
                RND: begin
                    c_r     <= rc;
                    flags_r <= rf;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed test of fp_mul_seq in binary32 and binary16 configurations.
module tb_fp_mul_seq;
    logic sysclk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    fp_mul_seq_if #(.EXP_W(8), .MAN_W(23)) bus ();
    fp_mul_seq_if #(.EXP_W(5), .MAN_W(10)) bus16 ();

    fp_mul_seq #(.EXP_W(8), .MAN_W(23)) dut (.sysclk(sysclk), .rst(rst), .bus(bus));
    fp_mul_seq #(.EXP_W(5), .MAN_W(10)) dut16 (.sysclk(sysclk), .rst(rst), .bus(bus16));

    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    // Latency counts edges with the acceptance edge as 1; -1 means no result.
    task automatic run32(input logic [31:0] xa, input logic [31:0] xb,
                         output logic [31:0] rc, output logic [3:0] rf,
                         output int lat, output int rdy);
        int n;
        bus.a = xa; bus.b = xb; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 100) begin @(posedge sysclk); #1; n++; end
        @(posedge sysclk); #1;
        bus.in_valid = 1'b0;
        lat = 1; rdy = 0;
        while (!bus.out_valid && lat < 100) begin
            if (bus.in_ready) rdy++;
            @(posedge sysclk); #1; lat++;
        end
        if (!bus.out_valid) lat = -1;
        rc = bus.c; rf = bus.flags;
        @(posedge sysclk); #1;
    endtask

    task automatic run16(input logic [15:0] xa, input logic [15:0] xb,
                         output logic [15:0] rc, output logic [3:0] rf, output int lat);
        int n;
        bus16.a = xa; bus16.b = xb; bus16.in_valid = 1'b1; bus16.out_ready = 1'b1;
        n = 0;
        while (!bus16.in_ready && n < 100) begin @(posedge sysclk); #1; n++; end
        @(posedge sysclk); #1;
        bus16.in_valid = 1'b0;
        lat = 1;
        while (!bus16.out_valid && lat < 100) begin @(posedge sysclk); #1; lat++; end
        if (!bus16.out_valid) lat = -1;
        rc = bus16.c; rf = bus16.flags;
        @(posedge sysclk); #1;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge sysclk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b expected 0 0", bus.in_ready, bus.out_valid);
        end
        checks++;
        if (bus.c !== 32'h0 || bus.flags !== 4'h0) begin
            errors++;
            $display("FAIL reset_out: c=%h flags=%b expected 00000000 0000", bus.c, bus.flags);
        end
        rst = 1'b0;
        @(posedge sysclk); #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus16.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: in_ready=%b/%b expected 1/1", bus.in_ready, bus16.in_ready);
        end
    endtask

    task automatic test_basic_latency;
        logic [31:0] rc; logic [3:0] rf; int lat, rdy;
        run32(32'h3FC00000, 32'h40000000, rc, rf, lat, rdy);
        checks++;
        if (rc !== 32'h40400000 || rf !== 4'b0000) begin
            errors++;
            $display("FAIL basic: c=%h flags=%b expected 40400000 0000", rc, rf);
        end
        checks++;
        if (lat !== 26) begin
            errors++;
            $display("FAIL latency32: got %0d expected 26", lat);
        end
        checks++;
        if (rdy !== 0) begin
            errors++;
            $display("FAIL busy_ready: in_ready high %0d cycles expected 0", rdy);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_pulse: out_valid=%b after handshake expected 0", bus.out_valid);
        end
    endtask

    task automatic test_rounding;
        logic [31:0] va [3] = '{32'hBF800000, 32'h3F800800, 32'h3F800001};
        logic [31:0] vb [3] = '{32'h40000000, 32'h3F800800, 32'h3F800001};
        logic [31:0] ec [3] = '{32'hC0000000, 32'h3F801000, 32'h3F800002};
        logic [3:0]  ef [3] = '{4'b0000, 4'b0001, 4'b0001};
        logic [31:0] rc; logic [3:0] rf; int lat, rdy;
        for (int i = 0; i < 3; i++) begin
            run32(va[i], vb[i], rc, rf, lat, rdy);
            checks++;
            if (rc !== ec[i] || rf !== ef[i]) begin
                errors++;
                $display("FAIL round_%0d: c=%h flags=%b expected %h %b", i, rc, rf, ec[i], ef[i]);
            end
        end
    endtask

    task automatic test_specials;
        logic [31:0] va [3] = '{32'h7F800000, 32'hFF800000, 32'h7F800001};
        logic [31:0] vb [3] = '{32'h00000000, 32'h40000000, 32'h3F800000};
        logic [31:0] ec [3] = '{32'h7FC00000, 32'hFF800000, 32'h7FC00000};
        logic [3:0]  ef [3] = '{4'b1000, 4'b0000, 4'b1000};
        logic [31:0] rc; logic [3:0] rf; int lat, rdy;
        for (int i = 0; i < 3; i++) begin
            run32(va[i], vb[i], rc, rf, lat, rdy);
            checks++;
            if (rc !== ec[i] || rf !== ef[i] || lat !== 26) begin
                errors++;
                $display("FAIL special_%0d: c=%h flags=%b lat=%0d expected %h %b 26", i, rc, rf, lat, ec[i], ef[i]);
            end
        end
    endtask

    task automatic test_ovf_unf;
        logic [31:0] va [3] = '{32'h7F000000, 32'h00800000, 32'h80000001};
        logic [31:0] vb [3] = '{32'h7F000000, 32'h00800000, 32'h80000001};
        logic [31:0] ec [3] = '{32'h7F800000, 32'h00000000, 32'h00000000};
        logic [3:0]  ef [3] = '{4'b0101, 4'b0011, 4'b0000};
        logic [31:0] rc; logic [3:0] rf; int lat, rdy;
        for (int i = 0; i < 3; i++) begin
            run32(va[i], vb[i], rc, rf, lat, rdy);
            checks++;
            if (rc !== ec[i] || rf !== ef[i]) begin
                errors++;
                $display("FAIL range_%0d: c=%h flags=%b expected %h %b", i, rc, rf, ec[i], ef[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int  n;
        logic stable;
        bus.a = 32'h3FC00000; bus.b = 32'h40000000; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge sysclk); #1;
        bus.in_valid = 1'b0;
        repeat (3) begin @(posedge sysclk); #1; end
        bus.a = 32'h40000000; bus.b = 32'h40000000; bus.in_valid = 1'b1;
        n = 0;
        while (!bus.out_valid && n < 100) begin @(posedge sysclk); #1; n++; end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.c !== 32'h40400000 || bus.flags !== 4'b0000) begin
            errors++;
            $display("FAIL bp_result: valid=%b c=%h flags=%b expected 1 40400000 0000", bus.out_valid, bus.c, bus.flags);
        end
        stable = 1'b1;
        repeat (10) begin
            @(posedge sysclk); #1;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.c !== 32'h40400000 || bus.flags !== 4'b0000)
                stable = 1'b0;
        end
        checks++;
        if (stable !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold: c=%h flags=%b valid=%b ready=%b expected held 40400000 0000 1 0", bus.c, bus.flags, bus.out_valid, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        @(posedge sysclk); #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: valid=%b ready=%b expected 0 1", bus.out_valid, bus.in_ready);
        end
        @(posedge sysclk); #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 100) begin @(posedge sysclk); #1; n++; end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.c !== 32'h40800000) begin
            errors++;
            $display("FAIL bp_next: valid=%b c=%h expected 1 40800000", bus.out_valid, bus.c);
        end
        @(posedge sysclk); #1;
    endtask

    task automatic test_reset_mid_op;
        logic seen;
        logic [31:0] rc; logic [3:0] rf; int lat, rdy;
        bus.a = 32'h3FC00000; bus.b = 32'h40000000; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge sysclk); #1;
        bus.in_valid = 1'b0;
        repeat (10) begin @(posedge sysclk); #1; end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_ready: in_ready=%b during reset expected 0", bus.in_ready);
        end
        @(posedge sysclk); #1;
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            if (bus.out_valid) seen = 1'b1;
            @(posedge sysclk); #1;
        end
        checks++;
        if (seen !== 1'b0 || bus.c !== 32'h0 || bus.flags !== 4'h0) begin
            errors++;
            $display("FAIL rst_abort: out_valid_seen=%b c=%h flags=%b expected 0 00000000 0000", seen, bus.c, bus.flags);
        end
        run32(32'h3FC00000, 32'h40000000, rc, rf, lat, rdy);
        checks++;
        if (rc !== 32'h40400000 || rf !== 4'b0000 || lat !== 26) begin
            errors++;
            $display("FAIL rst_recover: c=%h flags=%b lat=%0d expected 40400000 0000 26", rc, rf, lat);
        end
    endtask

    task automatic test_half;
        logic [15:0] rc; logic [3:0] rf; int lat;
        run16(16'h3E00, 16'h4000, rc, rf, lat);
        checks++;
        if (rc !== 16'h4200 || rf !== 4'b0000) begin
            errors++;
            $display("FAIL half: c=%h flags=%b expected 4200 0000", rc, rf);
        end
        checks++;
        if (lat !== 13) begin
            errors++;
            $display("FAIL latency16: got %0d expected 13", lat);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b0;
        bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.out_ready = 1'b0;
        test_reset;
        test_basic_latency;
        test_rounding;
        test_specials;
        test_ovf_unf;
        test_back_to_back;
        test_reset_mid_op;
        test_half;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp_mul_seq.md
Name: fp_mul_seq

Overview:
- Parametrised, multi-cycle IEEE-754 binary floating-point multiplier; successor to the combinational single-precision multiplier.
- Configurable exponent and mantissa widths; default is binary32.
- Adds valid/ready handshakes on input and output, round-to-nearest-even, special-value handling and exception flags.
- Uses an iterative shift-add mantissa datapath, so it fits in the datapath next to the ALU without a wide array multiplier.

Parameters:
- EXP_W, 8, exponent field width; BIAS = 2^(EXP_W-1)-1.
- MAN_W, 23, stored mantissa (fraction) width; word width W = 1+EXP_W+MAN_W.

Ports:
- sysclk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operands a, b valid.
- in_ready  output  1  block can accept operands.
- a  input  W  operand A, IEEE format {sign, exp, frac}.
- b  input  W  operand B.
- out_valid  output  1  result c and flags valid.
- out_ready  input  1  consumer accepts result.
- c  output  W  product.
- flags  output  4  {invalid, overflow, underflow, inexact}.

Behaviour:
- Reset values: in_ready=0 during rst, 1 from first cycle after; out_valid=0, c=0, flags=0, FSM=IDLE, all internal registers cleared.
- Reset mid-operation: rst aborts any operation, returns to IDLE, drops pending result; no out_valid follows.

FSM states:
- IDLE: in_ready=1. Acceptance when in_valid && in_ready at an edge. Latch sign=a.s^b.s, classify operands, latch significands {1,frac} (hidden bit 0 for subnormal), preload exponent sum ea+eb-BIAS. Go to MUL.
- MUL: MAN_W+1 cycles. One multiplier bit per cycle, shift-add into a 2*(MAN_W+1)-bit product register. After the last bit go to RND.
- RND: one cycle.
  - Normalise: if product MSB (bit 2*MAN_W+1) is set, shift right 1 and exp+1.
  - Form guard and sticky bits; round to nearest even. A mantissa carry-out renormalises and increments exp.
  - Apply exception rules; register c and flags. Go to DONE.
- DONE: out_valid=1. c and flags held stable until out_ready. On out_valid && out_ready, go to IDLE (out_valid=0 next cycle).
- in_ready=0 in MUL, RND and DONE. Fixed latency for all operands: out_valid rises exactly MAN_W+3 edges after the acceptance edge (26 by default). Minimum issue interval is MAN_W+4 cycles.
- in_valid is ignored outside IDLE.

Special cases (fixed latency still applies):
- Subnormal inputs are flushed to signed zero before classification; no flag is raised for the flush.
- Any NaN input -> canonical qNaN: sign 0, exp all ones, frac MSB 1, rest 0 (0x7FC00000). invalid=1 if either input is a signalling NaN (frac MSB 0, frac != 0).
- 0 × Inf -> canonical qNaN, invalid=1.
- Inf × finite nonzero, or Inf × Inf -> signed Inf, no flag.
- 0 × finite -> signed zero, no flag.

Normal results:
- Overflow: biased exp after rounding >= 2^EXP_W-1 -> signed Inf; overflow=1, inexact=1.
- Underflow: biased exp after rounding <= 0 -> signed zero (flush); underflow=1, inexact=1.
- Otherwise inexact = guard|sticky.

Test Plan:
- Basic product and latency: a=0x3FC00000 (1.5), b=0x40000000 (2.0), out_ready=1 -> c=0x40400000, flags=0. out_valid exactly 26 edges after acceptance, high for 1 cycle. in_ready=0 throughout.
- Signs and tie rounding: a=0xBF800000, b=0x40000000 -> c=0xC0000000.
  - a=b=0x3F800800 (exact tie, LSB even) -> c=0x3F801000, inexact=1.
  - a=b=0x3F800001 -> c=0x3F800002, inexact=1.
- Specials:
  - 0x7F800000 × 0x00000000 -> 0x7FC00000, invalid=1.
  - 0xFF800000 × 0x40000000 -> 0xFF800000, flags=0.
  - 0x7F800001 × 0x3F800000 -> 0x7FC00000, invalid=1.
- Overflow/underflow:
  - 0x7F000000 × 0x7F000000 -> 0x7F800000, flags=0101 ({invalid, overflow, underflow, inexact}).
  - 0x00800000 × 0x00800000 -> 0x00000000, flags=0011.
  - 0x80000001 × 0x80000001 (subnormals) -> 0x00000000, flags=0.
- Backpressure and in_valid in busy states: hold out_ready=0 for 10 cycles after out_valid -> c/flags stable, in_ready=0. Assert in_valid with new operands mid-MUL -> ignored. Raise out_ready -> IDLE next cycle, new operands accepted.
- Reset mid-op: pulse rst at cycle 10 of MUL -> out_valid never asserts for that operation, outputs 0. Next operation (1.5×2.0) completes normally with c=0x40400000.
- Parametrisation: EXP_W=5, MAN_W=10 (binary16): 0x3E00 × 0x4000 -> 0x4200; out_valid exactly 13 edges after acceptance.
